// File: rtl/pbdebounce_pkg.sv
// Shared defaults and width helpers for the push-button debouncer.
// Both counters are sized to hold their terminal value without wrapping.
package pbdebounce_pkg;

  localparam int DEF_N            = 4;
  localparam int DEF_STABLE_TICKS = 8;
  localparam int DEF_HOLD_TICKS   = 500;

  // Bits needed to hold the value max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pbdebounce_chan.sv
// One debounced button: 2-flop synchronizer, tick-gated stable counter,
// hold counter with a single long-press pulse, and level-change pulses.
module pbdebounce_chan
  import pbdebounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic pb_level,
  output logic pb_rise,
  output logic pb_fall,
  output logic pb_long
);

  localparam int SW = cnt_width(STABLE_TICKS);
  localparam int HW = cnt_width(HOLD_TICKS);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);

  logic [1:0]    sync_reg;
  logic          s;
  logic [SW-1:0] stable_reg, stable_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          level_reg, level_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic          long_reg, long_next;

  assign s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= '0;
      stable_reg <= '0;
      hold_reg   <= '0;
      level_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      long_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], btn};
      stable_reg <= stable_next;
      hold_reg   <= hold_next;
      level_reg  <= level_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      long_reg   <= long_next;
    end
  end

  always_comb begin
    stable_next = stable_reg;
    hold_next   = hold_reg;
    level_next  = level_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    long_next   = 1'b0;

    // Any sample matching the current level restarts the count.
    if (tick) begin
      if (s == level_reg) begin
        stable_next = '0;
      end else if (stable_reg == STABLE_MAX - 1'b1) begin
        stable_next = '0;
        level_next  = s;
        rise_next   = s;
        fall_next   = ~s;
      end else begin
        stable_next = stable_reg + 1'b1;
      end
    end

    // Saturates at HOLD_MAX so the long pulse fires once per press.
    if (!level_reg) begin
      hold_next = '0;
    end else if (tick && (hold_reg != HOLD_MAX)) begin
      hold_next = hold_reg + 1'b1;
      long_next = (hold_reg == HOLD_MAX - 1'b1);
    end
  end

  assign pb_level = level_reg;
  assign pb_rise  = rise_reg;
  assign pb_fall  = fall_reg;
  assign pb_long  = long_reg;

endmodule

// File: rtl/pbdebounce_n.sv
// N independent debounced push-button channels sharing one sample tick.
// The tick comes from an external clock divider.
module pbdebounce_n
  import pbdebounce_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] btn,
  output logic [N-1:0] pb_level,
  output logic [N-1:0] pb_rise,
  output logic [N-1:0] pb_fall,
  output logic [N-1:0] pb_long
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      pbdebounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .HOLD_TICKS   (HOLD_TICKS)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btn      (btn[gi]),
        .pb_level (pb_level[gi]),
        .pb_rise  (pb_rise[gi]),
        .pb_fall  (pb_fall[gi]),
        .pb_long  (pb_long[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pbdebounce_n.sv
// Directed bench for pbdebounce_n: N=4, STABLE_TICKS=8, HOLD_TICKS=20,
// one tick every 10 clk; expected values are hand-derived constants.
module tb_pbdebounce_n;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int HT = 20;
  localparam int TP = 10;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick  = 1'b0;
  logic [N-1:0] btn   = '0;
  logic [N-1:0] pb_level, pb_rise, pb_fall, pb_long;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int tick_no = 0;
  int both_cnt = 0;
  int rise_cnt[N];
  int fall_cnt[N];
  int long_cnt[N];
  int snap;

  pbdebounce_n #(.N(N), .STABLE_TICKS(ST), .HOLD_TICKS(HT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn      (btn),
    .pb_level (pb_level),
    .pb_rise  (pb_rise),
    .pb_fall  (pb_fall),
    .pb_long  (pb_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("check %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle; tick is high on every TP-th edge. Outputs sampled 1 ns after the edge.
  task automatic step();
    tick = (phase == TP - 1);
    @(posedge clk);
    #1;
    if (tick) tick_no++;
    tick  = 1'b0;
    phase = (phase + 1) % TP;
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] += int'(pb_rise[i]);
      fall_cnt[i] += int'(pb_fall[i]);
      long_cnt[i] += int'(pb_long[i]);
      if (pb_rise[i] && pb_fall[i]) both_cnt++;
    end
  endtask

  task automatic run_ticks(input int n);
    int target;
    target = tick_no + n;
    while (tick_no < target) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      long_cnt[i] = 0;
    end

    // Asynchronous reset without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {16'd0, pb_level, pb_rise, pb_fall, pb_long}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    phase = 0;

    // Clean press on channel 0
    btn = 4'b0001;
    run_ticks(ST - 1);
    check("clean_level_before", {28'd0, pb_level}, 32'h0);
    run_ticks(1);
    check("clean_rise_8th", {28'd0, pb_rise}, 32'h1);
    check("clean_level_8th", {28'd0, pb_level}, 32'h1);
    step();
    check("clean_rise_1cyc", {28'd0, pb_rise}, 32'h0);
    btn = 4'b0000;
    run_ticks(ST);
    check("clean_fall", {28'd0, pb_fall}, 32'h1);
    check("clean_counts", {8'd0, 8'(rise_cnt[0]), 8'(fall_cnt[0]), 8'(long_cnt[0])}, 32'h00010100);

    // Bounce on channel 1: 5 high, 1 low, then 8 high
    btn = 4'b0010;
    run_ticks(5);
    btn = 4'b0000;
    run_ticks(1);
    btn = 4'b0010;
    run_ticks(ST - 1);
    check("bounce_level_7", {28'd0, pb_level}, 32'h0);
    run_ticks(1);
    check("bounce_level_8", {28'd0, pb_level}, 32'h2);
    check("bounce_rise_cnt", 32'(rise_cnt[1]), 32'd1);
    btn = 4'b0000;
    run_ticks(ST);
    check("bounce_release", {28'd0, pb_level}, 32'h0);

    // Long press on channel 2: held 40 ticks
    btn = 4'b0100;
    run_ticks(ST);
    check("long_rise", {28'd0, pb_rise}, 32'h4);
    run_ticks(HT - 1);
    check("long_not_early", 32'(long_cnt[2]), 32'd0);
    run_ticks(1);
    check("long_pulse", {28'd0, pb_long}, 32'h4);
    step();
    check("long_pulse_1cyc", {28'd0, pb_long}, 32'h0);
    run_ticks(40 - ST - HT);
    check("long_single", 32'(long_cnt[2]), 32'd1);
    btn = 4'b0000;
    run_ticks(ST - 1);
    check("long_release_7", {28'd0, pb_level}, 32'h4);
    run_ticks(1);
    check("long_fall", {28'd0, pb_fall}, 32'h4);
    check("long_counts", {8'd0, 8'(rise_cnt[2]), 8'(fall_cnt[2]), 8'(long_cnt[2])}, 32'h00010101);

    // All channels at once
    btn = 4'b1111;
    run_ticks(ST);
    check("simul_rise", {28'd0, pb_rise}, 32'hF);
    btn = 4'b0000;
    run_ticks(ST);
    check("simul_fall", {28'd0, pb_fall}, 32'hF);

    // Reset at tick 5 of a press on channel 3
    btn = 4'b1000;
    run_ticks(5);
    rst_n = 1'b0;
    #1;
    check("rst_press_outputs", {16'd0, pb_level, pb_rise, pb_fall, pb_long}, 32'd0);
    #1 rst_n = 1'b1;
    run_ticks(ST - 1);
    check("rst_press_restart7", {28'd0, pb_level}, 32'h0);
    run_ticks(1);
    check("rst_press_restart8", {28'd0, pb_level}, 32'h8);

    // Reset during hold
    run_ticks(5);
    rst_n = 1'b0;
    #1;
    check("rst_hold_outputs", {16'd0, pb_level, pb_rise, pb_fall, pb_long}, 32'd0);
    #1 rst_n = 1'b1;
    run_ticks(ST - 1);
    check("rst_hold_restart7", {28'd0, pb_level}, 32'h0);
    run_ticks(1);
    check("rst_hold_restart8", {28'd0, pb_level}, 32'h8);
    btn = 4'b0000;
    run_ticks(ST);
    check("rst_release", {28'd0, pb_level}, 32'h0);
    check("rst_long_none", 32'(long_cnt[3]), 32'd0);

    // 3-clk glitch between ticks on channel 0
    snap = rise_cnt[0];
    btn = 4'b0001;
    repeat (3) step();
    btn = 4'b0000;
    run_ticks(ST + 1);
    check("glitch_level", {28'd0, pb_level}, 32'h0);
    check("glitch_rise_cnt", 32'(rise_cnt[0] - snap), 32'd0);

    check("never_rise_and_fall", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbdebounce_n.md
PBDEBOUNCE_N -- requirements
Module: pbdebounce_n

Interface
REQ-001 SHALL have parameter N, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter STABLE_TICKS, default 8: consecutive differing tick samples required to change a debounced level (1..255).
REQ-003 SHALL have parameter HOLD_TICKS, default 500: ticks of continuous debounced-high before a long-press pulse (1..65535).
REQ-004 SHALL have port clk  input  1: single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port tick  input  1: sample enable, one clk cycle wide (nominally every 1 ms).
REQ-007 SHALL have port btn  input  N: raw, asynchronous, bouncing button inputs.
REQ-008 SHALL have port pb_level  output  N: debounced level per channel.
REQ-009 SHALL have port pb_rise  output  N: one-clk pulse when pb_level goes 0->1.
REQ-010 SHALL have port pb_fall  output  N: one-clk pulse when pb_level goes 1->0.
REQ-011 SHALL have port pb_long  output  N: one-clk pulse when a press has been held HOLD_TICKS ticks.

Function
REQ-012 SHALL pass each btn bit through a 2-flop synchronizer clocked every clk cycle, not gated by tick; its output is s[i].
REQ-013 SHALL update debounce state only on cycles with tick=1; with tick=0, counters and pb_level hold.
REQ-014 On a tick with s[i]==pb_level[i], SHALL clear the channel's stable counter to 0 (any bounce restarts the count).
REQ-015 On a tick with s[i]!=pb_level[i], SHALL increment the stable counter; on the tick where the counter would reach STABLE_TICKS, SHALL set pb_level[i]<=s[i] and clear the counter.
REQ-016 With STABLE_TICKS=1, SHALL change pb_level on the first tick that sees a differing sample.
REQ-017 SHALL assert pb_rise[i]/pb_fall[i] for exactly one clk cycle, the same cycle pb_level[i] shows its new value; never both simultaneously.
REQ-018 SHALL count a hold counter per channel on each tick while pb_level[i]=1, cleared whenever pb_level[i]=0.
REQ-019 SHALL pulse pb_long[i] for one clk cycle when the hold counter reaches HOLD_TICKS, then saturate: no further pb_long until pb_level[i] falls and rises again.
REQ-020 SHALL start the hold count on the first tick after the rising edge (pb_long fires HOLD_TICKS ticks after pb_rise).
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels all produce their pulses in the same cycle.
REQ-022 Counter widths SHALL be $clog2(STABLE_TICKS+1) and $clog2(HOLD_TICKS+1); neither counter may wrap.

Reset
REQ-023 rst_n=0 SHALL immediately clear synchronizer flops, all counters, pb_level, pb_rise, pb_fall, pb_long to 0, regardless of clk.
REQ-024 Reset mid-count or mid-hold SHALL discard progress; after release a held button needs full STABLE_TICKS ticks to reassert pb_level.
REQ-025 rst_n deassertion is synchronized externally; the block adds no reset synchronizer.

Structure
REQ-026 Default parameter values and width helper constants SHALL live in the shared package pbdebounce_pkg.
REQ-027 One sub-module pbdebounce_chan (synchronizer, stable counter, hold counter, edge pulses for one bit) SHALL be instantiated N times via generate.
REQ-028 The block SHALL contain no tick generator; tick comes from the existing clock-divider.

Verification (N=4, STABLE_TICKS=8, HOLD_TICKS=20, tick every 10 clk)
REQ-029 Clean press: btn[0] 0->1 held -> pb_level[0]=1 and one pb_rise[0] pulse on the 8th tick after sync; other channels stay 0.
REQ-030 Bounce: btn[1] high 5 ticks, low 1 tick, high 8 ticks -> pb_level[1] rises only after the final 8th tick; exactly one pb_rise.
REQ-031 Long press: btn[2] held 40 ticks -> single pb_long[2] 20 ticks after pb_rise[2]; no second pulse; release gives one pb_fall[2] after 8 ticks.
REQ-032 Simultaneous: btn=4'b1111 at once -> pb_rise=4'b1111 in the same cycle.
REQ-033 Reset mid-operation: rst_n=0 at tick 5 of a press and again during hold -> all outputs 0 immediately; after release 8 more ticks required.
REQ-034 Glitch between ticks: btn pulse of 3 clk not overlapping any sampled tick -> no output change.
